// File: rtl/game_tick_sync.sv
// game_tick_sync
// Consumer end of the game-clock path. Synchronizes the slow clk_run_i toggle
// into the VGA clock domain and turns its edges into tick requests. A request
// is held until the next vertical-blank rise, then released as a one-cycle
// game tick, so game state only changes between frames. Also counts frames,
// flags coalesced requests, watches for a stalled run clock and supports
// pause/single-step for debug.
//
// Ports:
//   clk            40 MHz VGA clock; all logic runs on its rising edge
//   rst            asynchronous active-high reset
//   clk_run_i      game-run toggle, asynchronous to clk
//   vblank_i       vertical-blank level, synchronous to clk
//   pause_i        1 = suspend normal ticking (debug)
//   step_i         one-cycle pulse; while paused, arms a single tick
//   overrun_clr_i  one-cycle pulse; clears overrun_o
//   tick_o         one-cycle game tick
//   frame_cnt_o    number of ticks issued, wraps
//   pending_o      a tick is waiting for vblank
//   overrun_o      sticky; a request was merged into one already pending
//   stalled_o      no request seen for TIMEOUT_CYC cycles
module game_tick_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int FRAME_W     = 16,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int TO_W        = 21
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_run_i,
    input  logic               vblank_i,
    input  logic               pause_i,
    input  logic               step_i,
    input  logic               overrun_clr_i,
    output logic               tick_o,
    output logic [FRAME_W-1:0] frame_cnt_o,
    output logic               pending_o,
    output logic               overrun_o,
    output logic               stalled_o
);

    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   vb_q;
    logic                   step_arm;
    logic [TO_W-1:0]        wd_cnt;

    logic                   run_s;
    logic                   req;
    logic                   vb_rise;
    logic                   release_t;
    logic                   pending_d;
    logic                   arm_d;
    logic                   ovr_set;
    logic [TO_W-1:0]        wd_d;

    assign run_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        req       = (EDGE_MODE != 0) ? (run_s ^ hist_q) : (run_s & ~hist_q);
        vb_rise   = vblank_i & ~vb_q;
        release_t = 1'b0;
        pending_d = 1'b0;
        arm_d     = 1'b0;
        ovr_set   = 1'b0;

        if (pause_i) begin
            // Requests are dropped while paused; only a step can arm a tick.
            // step_i while already armed leaves the single arm in place.
            release_t = step_arm & vb_rise;
            arm_d     = release_t ? 1'b0 : (step_arm | step_i);
        end else begin
            // A request landing on the release cycle becomes the new pending
            // tick rather than an overrun.
            release_t = pending_o & vb_rise;
            pending_d = req | (pending_o & ~release_t);
            ovr_set   = req & pending_o & ~release_t;
        end

        if (req) begin
            wd_d = '0;
        end else if (wd_cnt == WD_LIMIT) begin
            wd_d = wd_cnt;
        end else begin
            wd_d = wd_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            hist_q      <= 1'b0;
            vb_q        <= 1'b0;
            step_arm    <= 1'b0;
            wd_cnt      <= '0;
            tick_o      <= 1'b0;
            frame_cnt_o <= '0;
            pending_o   <= 1'b0;
            overrun_o   <= 1'b0;
            stalled_o   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], clk_run_i};
            hist_q    <= run_s;
            vb_q      <= vblank_i;
            step_arm  <= arm_d;
            pending_o <= pending_d;
            wd_cnt    <= wd_d;
            stalled_o <= (wd_cnt == WD_LIMIT);
            tick_o    <= release_t;
            if (release_t) begin
                frame_cnt_o <= frame_cnt_o + FRAME_W'(1);
            end
            // A set in the same cycle as a clear wins.
            overrun_o <= ovr_set | (overrun_o & ~overrun_clr_i);
        end
    end

endmodule
